// File: rtl/ap_ctrl_trace_recorder_if.sv
// Bundles the observed ap_ctrl handshake and the outgoing record stream.
// master = the recorder, slave = the handshake source and record consumer.
interface ap_ctrl_trace_recorder_if #(
  parameter int TS_W = 32
);
  logic            mon_ap_start;
  logic            mon_ap_ready;
  logic            mon_ap_done;
  logic            mon_ap_continue;
  logic            rec_valid;
  logic            rec_ready;
  logic [1:0]      rec_kind;
  logic [TS_W-1:0] rec_ts;
  logic [TS_W-1:0] rec_data;

  modport master (
    input  mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue, rec_ready,
    output rec_valid, rec_kind, rec_ts, rec_data
  );

  modport slave (
    output mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue, rec_ready,
    input  rec_valid, rec_kind, rec_ts, rec_data
  );
endinterface

// File: rtl/ap_ctrl_trace_recorder.sv
// Timestamps ap_ctrl START/DONE events into a show-ahead record FIFO with overflow records.
// Optional macro APCTRL_TRACE_INTERVAL_EN makes START records carry the start-to-start interval.
module ap_ctrl_trace_recorder #(
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      enable,
  ap_ctrl_trace_recorder_if.master  bus,
  output logic [15:0]               drop_cnt,
  output logic                      busy
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] FULL_C = (CW+1)'(DEPTH);
  localparam logic [1:0] K_START = 2'b00;
  localparam logic [1:0] K_DONE  = 2'b01;
  localparam logic [1:0] K_OVF   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WAIT = 2'd2} state_t;

  state_t          state_q;
  logic            busy_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] start_ts_q;
`ifdef APCTRL_TRACE_INTERVAL_EN
  logic [TS_W-1:0] prev_start_ts_q;
  logic            have_prev_q;
`endif
  logic [1:0]      kind_mem_q [DEPTH];
  logic [TS_W-1:0] ts_mem_q   [DEPTH];
  logic [TS_W-1:0] data_mem_q [DEPTH];
  logic [CW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW:0]     count_q;
  logic            pending_ovf_q;
  logic [TS_W-1:0] drop_run_q;
  logic [15:0]     drop_cnt_q;

  logic            start_ev_s, done_ev_s, ev_s, pop_s, space_s;
  logic [TS_W-1:0] interval_s, latency_s;
  logic            push_s, drop_s, clear_ovf_s, set_ovf_s;
  logic [1:0]      push_kind_s;
  logic [TS_W-1:0] push_data_s;
  logic            ready_unused;

  assign ready_unused = bus.mon_ap_ready;

  assign start_ev_s = (state_q == ST_IDLE) && bus.mon_ap_start;
  assign done_ev_s  = (state_q == ST_RUN) && bus.mon_ap_done;
  assign ev_s       = enable && (start_ev_s || done_ev_s);
  assign pop_s      = (count_q != {(CW+1){1'b0}}) && bus.rec_ready;
  assign space_s    = (count_q != FULL_C) || pop_s;
  assign latency_s  = ts_q - start_ts_q;
`ifdef APCTRL_TRACE_INTERVAL_EN
  assign interval_s = have_prev_q ? (ts_q - prev_start_ts_q) : {TS_W{1'b0}};
`else
  assign interval_s = {TS_W{1'b0}};
`endif

  // Push/drop decision; a pending overflow record takes priority so ordering is preserved.
  always_comb begin
    push_s      = 1'b0;
    push_kind_s = K_START;
    push_data_s = {TS_W{1'b0}};
    drop_s      = 1'b0;
    clear_ovf_s = 1'b0;
    set_ovf_s   = 1'b0;
    if (pending_ovf_q) begin
      drop_s = ev_s;
      if (space_s) begin
        push_s      = 1'b1;
        push_kind_s = K_OVF;
        push_data_s = drop_run_q + {{(TS_W-1){1'b0}}, ev_s};
        clear_ovf_s = 1'b1;
      end else begin
        clear_ovf_s = 1'b0;
      end
    end else if (ev_s) begin
      if (space_s) begin
        push_s      = 1'b1;
        push_kind_s = start_ev_s ? K_START : K_DONE;
        push_data_s = start_ev_s ? interval_s : latency_s;
      end else begin
        drop_s    = 1'b1;
        set_ovf_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Handshake-tracking FSM with registered busy flag and start timestamps.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      start_ts_q      <= {TS_W{1'b0}};
`ifdef APCTRL_TRACE_INTERVAL_EN
      prev_start_ts_q <= {TS_W{1'b0}};
      have_prev_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mon_ap_start) begin
            state_q         <= ST_RUN;
            busy_q          <= 1'b1;
            start_ts_q      <= ts_q;
`ifdef APCTRL_TRACE_INTERVAL_EN
            prev_start_ts_q <= ts_q;
            have_prev_q     <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (bus.mon_ap_done) begin
            state_q <= bus.mon_ap_continue ? ST_IDLE : ST_WAIT;
            busy_q  <= !bus.mon_ap_continue;
          end
        end
        ST_WAIT: begin
          if (bus.mon_ap_continue) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Timestamp counter and overflow bookkeeping.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts_q          <= {TS_W{1'b0}};
      pending_ovf_q <= 1'b0;
      drop_run_q    <= {TS_W{1'b0}};
      drop_cnt_q    <= 16'h0000;
    end else begin
      if (enable) ts_q <= ts_q + TS_W'(1);
      if (clear_ovf_s) begin
        pending_ovf_q <= 1'b0;
        drop_run_q    <= {TS_W{1'b0}};
      end else if (set_ovf_s || drop_s) begin
        pending_ovf_q <= 1'b1;
        drop_run_q    <= drop_run_q + TS_W'(1);
      end
      if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  // Record storage; storage is cleared so the head reads zero after reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        kind_mem_q[i] <= 2'b00;
        ts_mem_q[i]   <= {TS_W{1'b0}};
        data_mem_q[i] <= {TS_W{1'b0}};
      end
      rd_ptr_q <= {CW{1'b0}};
      wr_ptr_q <= {CW{1'b0}};
      count_q  <= {(CW+1){1'b0}};
    end else begin
      if (push_s) begin
        kind_mem_q[wr_ptr_q] <= push_kind_s;
        ts_mem_q[wr_ptr_q]   <= ts_q;
        data_mem_q[wr_ptr_q] <= push_data_s;
        wr_ptr_q             <= wr_ptr_q + CW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + CW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (CW+1)'(1);
        2'b01:   count_q <= count_q - (CW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.rec_valid = (count_q != {(CW+1){1'b0}});
  assign bus.rec_kind  = kind_mem_q[rd_ptr_q];
  assign bus.rec_ts    = ts_mem_q[rd_ptr_q];
  assign bus.rec_data  = data_mem_q[rd_ptr_q];
  assign drop_cnt      = drop_cnt_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_ap_ctrl_trace_recorder.sv
// Bench for ap_ctrl_trace_recorder: directed scenarios plus random traffic against a queue model.
module tb_ap_ctrl_trace_recorder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, start = 1'b0, done = 1'b0, cont = 1'b0, rdy = 1'b0;
  logic [15:0] drop32, drop8;
  logic busy32, busy8;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ap_ctrl_trace_recorder_if #(.TS_W(32)) bus32 ();
  ap_ctrl_trace_recorder_if #(.TS_W(8))  bus8 ();

  assign bus32.mon_ap_start = start;    assign bus8.mon_ap_start = start;
  assign bus32.mon_ap_ready = done;     assign bus8.mon_ap_ready = done;
  assign bus32.mon_ap_done = done;      assign bus8.mon_ap_done = done;
  assign bus32.mon_ap_continue = cont;  assign bus8.mon_ap_continue = cont;
  assign bus32.rec_ready = rdy;         assign bus8.rec_ready = rdy;

  ap_ctrl_trace_recorder #(.TS_W(32), .DEPTH(DEPTH)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .enable(en), .bus(bus32.master), .drop_cnt(drop32), .busy(busy32));
  ap_ctrl_trace_recorder #(.TS_W(8), .DEPTH(DEPTH)) dut8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .enable(en), .bus(bus8.master), .drop_cnt(drop8), .busy(busy8));

  // Reference model: transaction phase, record queue and drop accounting.
  typedef struct {logic [1:0] kind; logic [31:0] ts; logic [31:0] data;} rec_t;
  rec_t mq[$];
  int m_phase, m_drop;
  logic [31:0] m_ts, m_start_ts, m_prev, m_run;
  bit m_have_prev, m_pend;

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_drop = 0; m_ts = 0; m_start_ts = 0; m_prev = 0; m_run = 0;
    m_have_prev = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit ev_start, ev_done, ev, pop, space;
    logic [31:0] ev_data;
    rec_t r;
    ev_start = (m_phase == 0) && start;
    ev_done  = (m_phase == 1) && done;
    ev_data  = 0;
    if (ev_start) begin
`ifdef APCTRL_TRACE_INTERVAL_EN
      ev_data = m_have_prev ? m_ts - m_prev : 32'd0;
`endif
      m_prev = m_ts; m_have_prev = 1; m_start_ts = m_ts; m_phase = 1;
    end else if (ev_done) begin
      ev_data = m_ts - m_start_ts;
      m_phase = cont ? 0 : 2;
    end else if (m_phase == 2 && cont) begin
      m_phase = 0;
    end
    ev = en && (ev_start || ev_done);
    pop = (mq.size() != 0) && rdy;
    space = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (ev && m_drop < 65535) m_drop++;
      if (space) begin
        r.kind = 2'b10; r.ts = m_ts; r.data = m_run + (ev ? 32'd1 : 32'd0);
        mq.push_back(r);
        m_pend = 0; m_run = 0;
      end else if (ev) begin
        m_run++;
      end
    end else if (ev) begin
      if (space) begin
        r.kind = ev_start ? 2'b00 : 2'b01; r.ts = m_ts; r.data = ev_data;
        mq.push_back(r);
      end else begin
        m_pend = 1; m_run++;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (en) m_ts++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    start = 0; done = 0; cont = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    start = 0; done = 0; cont = 0; rdy = 0; en = 0; rst_n = 0;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus32.rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", bus32.rec_valid); end
    total++; if (bus32.rec_kind !== 2'b00) begin bad++; $display("FAIL reset_kind: got %0h expected 0", bus32.rec_kind); end
    total++; if (bus32.rec_ts !== 32'd0 || bus32.rec_data !== 32'd0) begin bad++; $display("FAIL reset_ts_data: got %0h/%0h expected 0/0", bus32.rec_ts, bus32.rec_data); end
    total++; if (drop32 !== 16'd0 || busy32 !== 1'b0) begin bad++; $display("FAIL reset_drop_busy: got %0h/%0b expected 0/0", drop32, busy32); end
  endtask

  task automatic test_single();
    do_reset(); en = 1; rdy = 1;
    idle(5);
    start = 1; step(); start = 0;
    total++; if (bus32.rec_valid !== 1'b1 || bus32.rec_kind !== 2'b00 || bus32.rec_ts !== 32'd5 || bus32.rec_data !== 32'd0) begin
      bad++; $display("FAIL single_start: got v=%0b k=%0h ts=%0d d=%0d expected v=1 k=0 ts=5 d=0", bus32.rec_valid, bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
    total++; if (busy32 !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %0b expected 1", busy32); end
    idle(6);
    done = 1; cont = 1; step(); done = 0; cont = 0;
    total++; if (bus32.rec_valid !== 1'b1 || bus32.rec_kind !== 2'b01 || bus32.rec_ts !== 32'd12 || bus32.rec_data !== 32'd7) begin
      bad++; $display("FAIL single_done: got v=%0b k=%0h ts=%0d d=%0d expected v=1 k=1 ts=12 d=7", bus32.rec_valid, bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %0b expected 0", busy32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_int;
`ifdef APCTRL_TRACE_INTERVAL_EN
    exp_int = 32'd6;
`else
    exp_int = 32'd0;
`endif
    do_reset(); en = 1; rdy = 0;
    idle(5);
    start = 1; step();
    for (int i = 0; i < 4; i++) step();
    done = 1; cont = 1; step(); done = 0; cont = 0;
    step(); start = 0;
    total++; if (bus32.rec_kind !== 2'b00 || bus32.rec_ts !== 32'd5) begin bad++; $display("FAIL b2b_first: got k=%0h ts=%0d expected k=0 ts=5", bus32.rec_kind, bus32.rec_ts); end
    rdy = 1; step();
    total++; if (bus32.rec_kind !== 2'b01 || bus32.rec_ts !== 32'd10 || bus32.rec_data !== 32'd5) begin bad++; $display("FAIL b2b_done: got k=%0h ts=%0d d=%0d expected k=1 ts=10 d=5", bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
    step();
    total++; if (bus32.rec_valid !== 1'b1 || bus32.rec_kind !== 2'b00 || bus32.rec_ts !== 32'd11 || bus32.rec_data !== exp_int) begin
      bad++; $display("FAIL b2b_second_start: got v=%0b k=%0h ts=%0d d=%0d expected v=1 k=0 ts=11 d=%0d", bus32.rec_valid, bus32.rec_kind, bus32.rec_ts, bus32.rec_data, exp_int); end
    step(); rdy = 0;
  endtask

  task automatic test_continue_withheld();
    logic [31:0] exp_int;
`ifdef APCTRL_TRACE_INTERVAL_EN
    exp_int = 32'd11;
`else
    exp_int = 32'd0;
`endif
    do_reset(); en = 1; rdy = 1;
    idle(15);
    start = 1; step(); start = 0;
    idle(4);
    done = 1; cont = 0; step();
    total++; if (bus32.rec_kind !== 2'b01 || bus32.rec_ts !== 32'd20 || bus32.rec_data !== 32'd5) begin bad++; $display("FAIL wait_done: got k=%0h ts=%0d d=%0d expected k=1 ts=20 d=5", bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
    start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus32.rec_valid !== 1'b0 || busy32 !== 1'b1) begin bad++; $display("FAIL wait_hold%0d: got v=%0b busy=%0b expected v=0 busy=1", i, bus32.rec_valid, busy32); end
    end
    done = 0; cont = 1; step();
    total++; if (bus32.rec_valid !== 1'b0 || busy32 !== 1'b0) begin bad++; $display("FAIL wait_release: got v=%0b busy=%0b expected v=0 busy=0", bus32.rec_valid, busy32); end
    cont = 0; step(); start = 0;
    total++; if (bus32.rec_valid !== 1'b1 || bus32.rec_kind !== 2'b00 || bus32.rec_ts !== 32'd26 || bus32.rec_data !== exp_int) begin
      bad++; $display("FAIL wait_next_start: got v=%0b k=%0h ts=%0d d=%0d expected v=1 k=0 ts=26 d=%0d", bus32.rec_valid, bus32.rec_kind, bus32.rec_ts, bus32.rec_data, exp_int); end
  endtask

  task automatic test_overflow();
    do_reset(); en = 1; rdy = 0;
    for (int i = 0; i < 6; i++) begin
      start = 1; step(); start = 0;
      done = 1; cont = 1; step(); done = 0; cont = 0;
    end
    total++; if (drop32 !== 16'd4 || bus32.rec_valid !== 1'b1) begin bad++; $display("FAIL ovf_drop4: got drop=%0d v=%0b expected drop=4 v=1", drop32, bus32.rec_valid); end
    rdy = 1; start = 1; step(); start = 0;
    total++; if (drop32 !== 16'd5) begin bad++; $display("FAIL ovf_drop5: got %0d expected 5", drop32); end
    for (int k = 1; k < 8; k++) begin
      total++; if (bus32.rec_kind !== 2'(k % 2) || bus32.rec_ts !== 32'(k)) begin bad++; $display("FAIL ovf_held%0d: got k=%0h ts=%0d expected k=%0d ts=%0d", k, bus32.rec_kind, bus32.rec_ts, k % 2, k); end
      step();
    end
    total++; if (bus32.rec_valid !== 1'b1 || bus32.rec_kind !== 2'b10 || bus32.rec_ts !== 32'd12 || bus32.rec_data !== 32'd5) begin
      bad++; $display("FAIL ovf_record: got v=%0b k=%0h ts=%0d d=%0d expected v=1 k=2 ts=12 d=5", bus32.rec_valid, bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
    step();
    total++; if (bus32.rec_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %0b expected 0", bus32.rec_valid); end
  endtask

  task automatic test_wrap();
    do_reset(); en = 1; rdy = 1;
    idle(250);
    start = 1; step(); start = 0;
    idle(9);
    done = 1; cont = 1; step(); done = 0; cont = 0;
    total++; if (bus8.rec_kind !== 2'b01 || bus8.rec_ts !== 8'd4 || bus8.rec_data !== 8'd10) begin bad++; $display("FAIL wrap_done8: got k=%0h ts=%0d d=%0d expected k=1 ts=4 d=10", bus8.rec_kind, bus8.rec_ts, bus8.rec_data); end
    total++; if (bus32.rec_ts !== 32'd260 || bus32.rec_data !== 32'd10) begin bad++; $display("FAIL wrap_done32: got ts=%0d d=%0d expected ts=260 d=10", bus32.rec_ts, bus32.rec_data); end
  endtask

  task automatic test_reset_mid_run();
    do_reset(); en = 1; rdy = 0;
    start = 1; step(); start = 0;
    done = 1; cont = 1; step(); done = 0; cont = 0;
    start = 1; step(); start = 0;
    total++; if (bus32.rec_valid !== 1'b1 || busy32 !== 1'b1) begin bad++; $display("FAIL midrst_pre: got v=%0b busy=%0b expected 1/1", bus32.rec_valid, busy32); end
    rst_n = 0; #1;
    total++; if (bus32.rec_valid !== 1'b0 || busy32 !== 1'b0) begin bad++; $display("FAIL midrst_async: got v=%0b busy=%0b expected 0/0", bus32.rec_valid, busy32); end
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    idle(3);
    start = 1; step(); start = 0;
    total++; if (bus32.rec_kind !== 2'b00 || bus32.rec_ts !== 32'd3 || bus32.rec_data !== 32'd0) begin bad++; $display("FAIL midrst_restart: got k=%0h ts=%0d d=%0d expected k=0 ts=3 d=0", bus32.rec_kind, bus32.rec_ts, bus32.rec_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 3) == 0;
      done  = ($urandom % 3) == 0;
      cont  = ($urandom % 4) != 0;
      en    = ($urandom % 8) != 0;
      rdy   = (((i / 50) % 3) == 1) ? 1'b0 : 1'($urandom % 2);
      step();
      total++; if (bus32.rec_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", i, bus32.rec_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        total++; if (bus32.rec_kind !== mq[0].kind || bus32.rec_ts !== mq[0].ts || bus32.rec_data !== mq[0].data) begin
          bad++; $display("FAIL rnd_head@%0d: got k=%0h ts=%0d d=%0d expected k=%0h ts=%0d d=%0d", i, bus32.rec_kind, bus32.rec_ts, bus32.rec_data, mq[0].kind, mq[0].ts, mq[0].data); end
      end
      total++; if (drop32 !== 16'(m_drop) || busy32 !== (m_phase != 0)) begin bad++; $display("FAIL rnd_drop_busy@%0d: got %0d/%0b expected %0d/%0b", i, drop32, busy32, m_drop, m_phase != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_continue_withheld();
    test_overflow();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
